// File: rtl/fir_stream_arb.sv
// Two-requester packet arbiter in front of a shared FIR; a 1-bit tag FIFO
// remembers grant order so FIR result packets are routed back to their owner.
module fir_stream_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic                         S0_AXIS_TVALID,
  output logic                         S0_AXIS_TREADY,
  input  logic                         S0_AXIS_TLAST,
  input  logic [DATA_WIDTH-1:0]        S0_AXIS_TDATA,
  input  logic                         S1_AXIS_TVALID,
  output logic                         S1_AXIS_TREADY,
  input  logic                         S1_AXIS_TLAST,
  input  logic [DATA_WIDTH-1:0]        S1_AXIS_TDATA,
  output logic                         FIR_IN_TVALID,
  input  logic                         FIR_IN_TREADY,
  output logic                         FIR_IN_TLAST,
  output logic [DATA_WIDTH-1:0]        FIR_IN_TDATA,
  input  logic                         FIR_OUT_TVALID,
  output logic                         FIR_OUT_TREADY,
  input  logic                         FIR_OUT_TLAST,
  input  logic [DATA_WIDTH-1:0]        FIR_OUT_TDATA,
  output logic                         M0_AXIS_TVALID,
  input  logic                         M0_AXIS_TREADY,
  output logic                         M0_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0]        M0_AXIS_TDATA,
  output logic                         M1_AXIS_TVALID,
  input  logic                         M1_AXIS_TREADY,
  output logic                         M1_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0]        M1_AXIS_TDATA,
  output logic [1:0]                   GRANT,
  output logic [$clog2(TAG_DEPTH):0]   INFLIGHT
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TAG_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2;

  logic [1:0]           state;
  logic                 rr_ptr;   // last granted requester
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, empty, head, sel, push, pop, in_last;

  always_comb begin
    full  = (count == DEPTH_C);
    empty = (count == '0);
    head  = tag_mem[rd_ptr];
    sel   = (S0_AXIS_TVALID && S1_AXIS_TVALID) ? ~rr_ptr : S1_AXIS_TVALID;
    push  = (state == IDLE) && !full && (S0_AXIS_TVALID || S1_AXIS_TVALID);
    pop   = !empty && FIR_OUT_TVALID && FIR_OUT_TLAST &&
            (head ? M1_AXIS_TREADY : M0_AXIS_TREADY);
  end

  // Input side: zero-latency pass-through of the granted requester
  always_comb begin
    S0_AXIS_TREADY = 1'b0;
    S1_AXIS_TREADY = 1'b0;
    FIR_IN_TVALID  = 1'b0;
    FIR_IN_TLAST   = 1'b0;
    FIR_IN_TDATA   = '0;
    case (state)
      GNT0: begin
        FIR_IN_TVALID  = S0_AXIS_TVALID;
        FIR_IN_TLAST   = S0_AXIS_TLAST;
        FIR_IN_TDATA   = S0_AXIS_TDATA;
        S0_AXIS_TREADY = FIR_IN_TREADY;
      end
      GNT1: begin
        FIR_IN_TVALID  = S1_AXIS_TVALID;
        FIR_IN_TLAST   = S1_AXIS_TLAST;
        FIR_IN_TDATA   = S1_AXIS_TDATA;
        S1_AXIS_TREADY = FIR_IN_TREADY;
      end
      default: ;
    endcase
    in_last = FIR_IN_TVALID && FIR_IN_TREADY && FIR_IN_TLAST;
  end

  // Output side: route FIR results by the oldest outstanding tag
  always_comb begin
    FIR_OUT_TREADY = 1'b0;
    M0_AXIS_TVALID = 1'b0;
    M0_AXIS_TLAST  = 1'b0;
    M0_AXIS_TDATA  = '0;
    M1_AXIS_TVALID = 1'b0;
    M1_AXIS_TLAST  = 1'b0;
    M1_AXIS_TDATA  = '0;
    if (!empty) begin
      if (head) begin
        M1_AXIS_TVALID = FIR_OUT_TVALID;
        M1_AXIS_TLAST  = FIR_OUT_TLAST;
        M1_AXIS_TDATA  = FIR_OUT_TDATA;
        FIR_OUT_TREADY = M1_AXIS_TREADY;
      end else begin
        M0_AXIS_TVALID = FIR_OUT_TVALID;
        M0_AXIS_TLAST  = FIR_OUT_TLAST;
        M0_AXIS_TDATA  = FIR_OUT_TDATA;
        FIR_OUT_TREADY = M0_AXIS_TREADY;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state  <= IDLE;
      rr_ptr <= 1'b1;
    end else begin
      case (state)
        IDLE:       if (push) state <= sel ? GNT1 : GNT0;
        GNT0, GNT1: if (in_last) begin
          state  <= IDLE;
          rr_ptr <= (state == GNT1);
        end
        default:    state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign GRANT    = {state == GNT1, state == GNT0};
  assign INFLIGHT = count;
endmodule

// File: tb/tb_fir_stream_arb.sv
// Bench for fir_stream_arb: vector table in a held grant, directed corner
// sequences, and a randomized end-to-end run against a packet-level model.
module tb_fir_stream_arb;
  localparam int DW = 16, TD = 4, IW = $clog2(TD) + 1;
  localparam logic [DW-1:0] XK = 16'h5A5A;

  logic ACLK = 1'b0, ARESETN;
  logic S0_AXIS_TVALID, S0_AXIS_TREADY, S0_AXIS_TLAST;
  logic S1_AXIS_TVALID, S1_AXIS_TREADY, S1_AXIS_TLAST;
  logic FIR_IN_TVALID, FIR_IN_TREADY, FIR_IN_TLAST;
  logic FIR_OUT_TVALID, FIR_OUT_TREADY, FIR_OUT_TLAST;
  logic M0_AXIS_TVALID, M0_AXIS_TREADY, M0_AXIS_TLAST;
  logic M1_AXIS_TVALID, M1_AXIS_TREADY, M1_AXIS_TLAST;
  logic [DW-1:0] S0_AXIS_TDATA, S1_AXIS_TDATA, FIR_IN_TDATA, FIR_OUT_TDATA;
  logic [DW-1:0] M0_AXIS_TDATA, M1_AXIS_TDATA;
  logic [1:0] GRANT;
  logic [IW-1:0] INFLIGHT;

  int n_tests = 0, n_fail = 0;

  fir_stream_arb #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_AXIS_TVALID(S0_AXIS_TVALID), .S0_AXIS_TREADY(S0_AXIS_TREADY),
    .S0_AXIS_TLAST(S0_AXIS_TLAST), .S0_AXIS_TDATA(S0_AXIS_TDATA),
    .S1_AXIS_TVALID(S1_AXIS_TVALID), .S1_AXIS_TREADY(S1_AXIS_TREADY),
    .S1_AXIS_TLAST(S1_AXIS_TLAST), .S1_AXIS_TDATA(S1_AXIS_TDATA),
    .FIR_IN_TVALID(FIR_IN_TVALID), .FIR_IN_TREADY(FIR_IN_TREADY),
    .FIR_IN_TLAST(FIR_IN_TLAST), .FIR_IN_TDATA(FIR_IN_TDATA),
    .FIR_OUT_TVALID(FIR_OUT_TVALID), .FIR_OUT_TREADY(FIR_OUT_TREADY),
    .FIR_OUT_TLAST(FIR_OUT_TLAST), .FIR_OUT_TDATA(FIR_OUT_TDATA),
    .M0_AXIS_TVALID(M0_AXIS_TVALID), .M0_AXIS_TREADY(M0_AXIS_TREADY),
    .M0_AXIS_TLAST(M0_AXIS_TLAST), .M0_AXIS_TDATA(M0_AXIS_TDATA),
    .M1_AXIS_TVALID(M1_AXIS_TVALID), .M1_AXIS_TREADY(M1_AXIS_TREADY),
    .M1_AXIS_TLAST(M1_AXIS_TLAST), .M1_AXIS_TDATA(M1_AXIS_TDATA),
    .GRANT(GRANT), .INFLIGHT(INFLIGHT)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic idle_inputs();
    S0_AXIS_TVALID = 0; S0_AXIS_TLAST = 0; S0_AXIS_TDATA = '0;
    S1_AXIS_TVALID = 0; S1_AXIS_TLAST = 0; S1_AXIS_TDATA = '0;
    FIR_IN_TREADY = 0; FIR_OUT_TVALID = 0; FIR_OUT_TLAST = 0; FIR_OUT_TDATA = '0;
    M0_AXIS_TREADY = 0; M1_AXIS_TREADY = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    ARESETN = 0;
    step(); step();
    ARESETN = 1;
  endtask

  // Every tvalid/tready output in one vector: {s0r,s1r,fiv,for,m0v,m1v}
  function automatic logic [5:0] hs();
    return {S0_AXIS_TREADY, S1_AXIS_TREADY, FIR_IN_TVALID, FIR_OUT_TREADY,
            M0_AXIS_TVALID, M1_AXIS_TVALID};
  endfunction

  typedef struct packed {
    logic s0v, s1v, fir, fov, m0r, m1r;
    logic [5:0] exp;
  } vec_t;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t src0_q[$], src1_q[$], fir_q[$], exp0_q[$], exp1_q[$];

  initial begin
    vec_t vt[6];
    vt[0] = {6'b111111, 6'b101110};
    vt[1] = {6'b011001, 6'b100000};
    vt[2] = {6'b100100, 6'b001010};
    vt[3] = {6'b110010, 6'b001100};
    vt[4] = {6'b000101, 6'b000010};
    vt[5] = {6'b101011, 6'b101100};

    // Reset state with busy-looking inputs
    idle_inputs();
    ARESETN = 0;
    S0_AXIS_TVALID = 1; S1_AXIS_TVALID = 1; FIR_IN_TREADY = 1;
    FIR_OUT_TVALID = 1; M0_AXIS_TREADY = 1; M1_AXIS_TREADY = 1;
    step();
    chk("rst_handshakes", hs(), 6'b0);
    chk("rst_grant", GRANT, 2'b00);
    chk("rst_inflight", INFLIGHT, 0);

    // Vector table while grant 0 is held and tag 0 is at the head
    reset_dut();
    S0_AXIS_TVALID = 1;
    step();
    chk("tbl_grant", GRANT, 2'b01);
    chk("tbl_inflight", INFLIGHT, 1);
    for (int i = 0; i < 6; i++) begin
      {S0_AXIS_TVALID, S1_AXIS_TVALID, FIR_IN_TREADY, FIR_OUT_TVALID,
       M0_AXIS_TREADY, M1_AXIS_TREADY} = {vt[i].s0v, vt[i].s1v, vt[i].fir,
                                          vt[i].fov, vt[i].m0r, vt[i].m1r};
      S0_AXIS_TDATA = DW'(16'h1230 + i);
      FIR_OUT_TDATA = DW'(16'h4560 + i);
      #1;
      chk("tbl_handshake", hs(), vt[i].exp);
      chk("tbl_in_data", FIR_IN_TDATA, DW'(16'h1230 + i));
      chk("tbl_out_data", {M1_AXIS_TDATA, M0_AXIS_TDATA}, {16'h0, DW'(16'h4560 + i)});
      step();
    end
    chk("tbl_grant_held", GRANT, 2'b01);
    chk("tbl_inflight_held", INFLIGHT, 1);

    // Tie after reset: S0 then S1, results routed in grant order
    reset_dut();
    S0_AXIS_TVALID = 1; S0_AXIS_TDATA = 16'hA000;
    S1_AXIS_TVALID = 1; S1_AXIS_TDATA = 16'hB000;
    FIR_IN_TREADY = 1; M0_AXIS_TREADY = 1; M1_AXIS_TREADY = 1;
    #1 chk("tie_idle_grant", GRANT, 2'b00);
    step();
    chk("tie_first_grant", GRANT, 2'b01);
    for (int b = 0; b < 3; b++) begin
      S0_AXIS_TDATA = DW'(16'hA000 + b); S0_AXIS_TLAST = (b == 2);
      #1 chk("tie_s0_pass", {FIR_IN_TVALID, FIR_IN_TLAST, FIR_IN_TDATA}, {1'b1, b == 2, DW'(16'hA000 + b)});
      chk("tie_s1_blocked", S1_AXIS_TREADY, 0);
      step();
    end
    S0_AXIS_TVALID = 0;
    chk("tie_bubble", GRANT, 2'b00);
    step();
    chk("tie_second_grant", GRANT, 2'b10);
    chk("tie_inflight2", INFLIGHT, 2);
    for (int b = 0; b < 3; b++) begin
      S1_AXIS_TDATA = DW'(16'hB000 + b); S1_AXIS_TLAST = (b == 2);
      #1 chk("tie_s1_pass", {FIR_IN_TVALID, FIR_IN_TDATA}, {1'b1, DW'(16'hB000 + b)});
      step();
    end
    S1_AXIS_TVALID = 0;
    FIR_OUT_TVALID = 1;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) begin
        FIR_OUT_TDATA = DW'(16'hC000 + p * 16 + b); FIR_OUT_TLAST = (b == 2);
        #1 chk("tie_route", {M0_AXIS_TVALID, M1_AXIS_TVALID}, (p == 0) ? 2'b10 : 2'b01);
        chk("tie_route_data", (p == 0) ? {M0_AXIS_TDATA, M1_AXIS_TDATA} : {M1_AXIS_TDATA, M0_AXIS_TDATA},
            {DW'(16'hC000 + p * 16 + b), 16'h0});
        step();
      end
      chk("tie_pop", INFLIGHT, 1 - p);
    end
    FIR_OUT_TVALID = 0;

    // Back-to-back single-beat packets from S0: one bubble between beats
    reset_dut();
    S0_AXIS_TVALID = 1; S0_AXIS_TLAST = 1; S0_AXIS_TDATA = 16'h0011; FIR_IN_TREADY = 1;
    #1 chk("b2b_c0", FIR_IN_TVALID, 0);
    step(); chk("b2b_c1", {FIR_IN_TVALID, FIR_IN_TDATA}, {1'b1, 16'h0011});
    chk("b2b_inf1", INFLIGHT, 1);
    step(); S0_AXIS_TDATA = 16'h0022;
    #1 chk("b2b_c2", FIR_IN_TVALID, 0);
    step(); chk("b2b_c3", {FIR_IN_TVALID, FIR_IN_TDATA}, {1'b1, 16'h0022});
    chk("b2b_inf2", INFLIGHT, 2);
    step(); S0_AXIS_TVALID = 0;
    #1 chk("b2b_fir_out_held", FIR_OUT_TREADY, 0);

    // Fill the tag FIFO, withhold the fifth grant, then wrap and back-pressure
    reset_dut();
    S0_AXIS_TVALID = 1; S0_AXIS_TLAST = 1; S1_AXIS_TVALID = 1; S1_AXIS_TLAST = 1;
    FIR_IN_TREADY = 1;
    for (int k = 0; k < 4; k++) begin
      step(); chk("full_alt_grant", GRANT, (k % 2) ? 2'b10 : 2'b01);
      step();
    end
    chk("full_inflight4", INFLIGHT, 4);
    step(); step();
    chk("full_withheld", {GRANT, S0_AXIS_TREADY, S1_AXIS_TREADY}, 4'b0000);
    FIR_OUT_TVALID = 1; FIR_OUT_TLAST = 1; M0_AXIS_TREADY = 1;
    #1 chk("full_head0", {M0_AXIS_TVALID, M1_AXIS_TVALID}, 2'b10);
    step(); FIR_OUT_TVALID = 0;
    chk("full_after_pop", INFLIGHT, 3);
    step();
    chk("full_fifth_grant", GRANT, 2'b01);
    chk("full_inflight_again", INFLIGHT, 4);
    step(); S0_AXIS_TVALID = 0; S1_AXIS_TVALID = 0;
    FIR_OUT_TVALID = 1; M0_AXIS_TREADY = 1; M1_AXIS_TREADY = 0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("bp_m1_stall", {FIR_OUT_TREADY, M0_AXIS_TVALID, M1_AXIS_TVALID}, 3'b001);
      step();
    end
    chk("bp_no_pop", INFLIGHT, 4);
    M1_AXIS_TREADY = 1;
    #1 chk("bp_release", FIR_OUT_TREADY, 1);
    step(); chk("bp_popped", INFLIGHT, 3);
    for (int k = 0; k < 3; k++) begin
      #1 chk("wrap_route", {M0_AXIS_TVALID, M1_AXIS_TVALID}, (k % 2) ? 2'b01 : 2'b10);
      step();
    end
    chk("wrap_drained", INFLIGHT, 0);
    FIR_OUT_TVALID = 0;

    // Simultaneous push and pop at INFLIGHT=2 across the write-pointer wrap
    reset_dut();
    S0_AXIS_TVALID = 1; S0_AXIS_TLAST = 1; S1_AXIS_TVALID = 1; S1_AXIS_TLAST = 1;
    FIR_IN_TREADY = 1; M0_AXIS_TREADY = 1; M1_AXIS_TREADY = 1;
    repeat (6) step();
    S0_AXIS_TVALID = 0; S1_AXIS_TVALID = 0;
    chk("pp_inflight3", INFLIGHT, 3);
    FIR_OUT_TVALID = 1; FIR_OUT_TLAST = 1;
    step();
    FIR_OUT_TVALID = 0;
    chk("pp_inflight2", INFLIGHT, 2);
    S1_AXIS_TVALID = 1; FIR_OUT_TVALID = 1;
    #1 chk("pp_head1", M1_AXIS_TVALID, 1);
    step();
    FIR_OUT_TVALID = 0;
    chk("pp_inflight_same", INFLIGHT, 2);
    chk("pp_grant", GRANT, 2'b10);
    step(); S1_AXIS_TVALID = 0; S0_AXIS_TVALID = 1;
    step(); chk("pp_wrap_grant", GRANT, 2'b01);
    step(); S0_AXIS_TVALID = 0;
    chk("pp_inflight3b", INFLIGHT, 3);
    FIR_OUT_TVALID = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("pp_route", {M0_AXIS_TVALID, M1_AXIS_TVALID}, (k == 1) ? 2'b01 : 2'b10);
      step();
    end
    FIR_OUT_TVALID = 0;
    chk("pp_empty", INFLIGHT, 0);

    // Asynchronous reset in the middle of a GNT1 packet
    reset_dut();
    S1_AXIS_TVALID = 1; FIR_IN_TREADY = 1; M1_AXIS_TREADY = 1;
    step(); step();
    chk("ar_mid_grant", GRANT, 2'b10);
    FIR_OUT_TVALID = 1;
    #2 ARESETN = 0;
    #1 chk("ar_outputs", hs(), 6'b0);
    chk("ar_grant_inflight", {GRANT, 3'(INFLIGHT)}, 5'b0);
    step();
    ARESETN = 1; FIR_OUT_TVALID = 0;
    S0_AXIS_TVALID = 1; S0_AXIS_TLAST = 1; S1_AXIS_TLAST = 1;
    step(); chk("ar_tie_s0", GRANT, 2'b01);

    // Randomized end-to-end run: FIR model is XOR-with-constant on each beat
    reset_dut();
    for (int p = 0; p < 40; p++) begin
      for (int s = 0; s < 2; s++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          beat_t bt;
          bt.d = DW'((s << 15) | (p << 3) | b);
          bt.l = (b == len - 1);
          if (s == 0) src0_q.push_back(bt); else src1_q.push_back(bt);
          bt.d = bt.d ^ XK;
          if (s == 0) exp0_q.push_back(bt); else exp1_q.push_back(bt);
        end
      end
    end
    begin
      int cyc, pkt_src;
      logic acc0, acc1, fin, fo, m0a, m1a;
      cyc = 0; pkt_src = -1;
      while ((exp0_q.size() + exp1_q.size()) != 0 && cyc < 20000) begin
        @(negedge ACLK);
        acc0 = S0_AXIS_TVALID && S0_AXIS_TREADY;
        acc1 = S1_AXIS_TVALID && S1_AXIS_TREADY;
        fin  = FIR_IN_TVALID && FIR_IN_TREADY;
        fo   = FIR_OUT_TVALID && FIR_OUT_TREADY;
        m0a  = M0_AXIS_TVALID && M0_AXIS_TREADY;
        m1a  = M1_AXIS_TVALID && M1_AXIS_TREADY;
        if (GRANT == 2'b11 || INFLIGHT > TD) chk("rnd_status_legal", {GRANT, 3'(INFLIGHT)}, 5'b0);
        if (acc0 || acc1 || fin) begin
          chk("rnd_in_handshake", {acc0, acc1, fin}, FIR_IN_TDATA[DW-1] ? 3'b011 : 3'b101);
          if (acc0 && src0_q.size() > 0) chk("rnd_in_data0", {FIR_IN_TLAST, FIR_IN_TDATA}, {src0_q[0].l, src0_q[0].d});
          if (acc1 && src1_q.size() > 0) chk("rnd_in_data1", {FIR_IN_TLAST, FIR_IN_TDATA}, {src1_q[0].l, src1_q[0].d});
          if (pkt_src >= 0) chk("rnd_no_midpkt_switch", 32'(FIR_IN_TDATA[DW-1]), pkt_src);
          pkt_src = FIR_IN_TLAST ? -1 : int'(FIR_IN_TDATA[DW-1]);
        end
        if (fo || m0a || m1a) chk("rnd_out_handshake", {m0a, m1a}, {fo && M0_AXIS_TVALID, fo && M1_AXIS_TVALID});
        if (m0a) begin
          if (exp0_q.size() == 0) chk("rnd_m0_extra", 1, 0);
          else begin
            chk("rnd_m0_data", {M0_AXIS_TLAST, M0_AXIS_TDATA}, {exp0_q[0].l, exp0_q[0].d});
            void'(exp0_q.pop_front());
          end
        end
        if (m1a) begin
          if (exp1_q.size() == 0) chk("rnd_m1_extra", 1, 0);
          else begin
            chk("rnd_m1_data", {M1_AXIS_TLAST, M1_AXIS_TDATA}, {exp1_q[0].l, exp1_q[0].d});
            void'(exp1_q.pop_front());
          end
        end
        if (fin) begin
          beat_t bt;
          bt.d = FIR_IN_TDATA; bt.l = FIR_IN_TLAST;
          fir_q.push_back(bt);
        end
        if (acc0 && src0_q.size() > 0) void'(src0_q.pop_front());
        if (acc1 && src1_q.size() > 0) void'(src1_q.pop_front());
        if (fo && fir_q.size() > 0) void'(fir_q.pop_front());
        step();
        // Sources and FIR model hold a presented beat until it is taken
        if (!(S0_AXIS_TVALID && !acc0)) begin
          S0_AXIS_TVALID = (src0_q.size() > 0) && ($urandom_range(0, 3) != 0);
          if (src0_q.size() > 0) {S0_AXIS_TLAST, S0_AXIS_TDATA} = {src0_q[0].l, src0_q[0].d};
        end
        if (!(S1_AXIS_TVALID && !acc1)) begin
          S1_AXIS_TVALID = (src1_q.size() > 0) && ($urandom_range(0, 3) != 0);
          if (src1_q.size() > 0) {S1_AXIS_TLAST, S1_AXIS_TDATA} = {src1_q[0].l, src1_q[0].d};
        end
        if (!(FIR_OUT_TVALID && !fo)) begin
          FIR_OUT_TVALID = (fir_q.size() > 0) && ($urandom_range(0, 3) != 0);
          if (fir_q.size() > 0) {FIR_OUT_TLAST, FIR_OUT_TDATA} = {fir_q[0].l, fir_q[0].d ^ XK};
        end
        FIR_IN_TREADY  = ($urandom_range(0, 3) != 0);
        M0_AXIS_TREADY = ($urandom_range(0, 2) != 0);
        M1_AXIS_TREADY = ($urandom_range(0, 2) != 0);
        cyc++;
      end
      chk("rnd_all_delivered", exp0_q.size() + exp1_q.size(), 0);
      chk("rnd_inflight_end", INFLIGHT, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_stream_arb.md
FIR_STREAM_ARB -- requirements
Module: fir_stream_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width of every TDATA port.
REQ-002 Parameter TAG_DEPTH, default 4: tag FIFO depth (packets in flight through FIR); power of two, >=2.
REQ-003 ACLK  in  1  single clock; all state on rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 S0_AXIS_TVALID/TREADY/TLAST  in/out/in  1 each  requester 0 input stream.
REQ-006 S0_AXIS_TDATA  in  DATA_WIDTH  requester 0 data.
REQ-007 S1_AXIS_TVALID/TREADY/TLAST/TDATA  as REQ-005/006  requester 1 input stream.
REQ-008 FIR_IN_TVALID/TLAST  out  1; FIR_IN_TREADY  in  1; FIR_IN_TDATA  out  DATA_WIDTH  stream to shared FIR input.
REQ-009 FIR_OUT_TVALID/TLAST  in  1; FIR_OUT_TREADY  out  1; FIR_OUT_TDATA  in  DATA_WIDTH  stream from FIR output.
REQ-010 M0_AXIS_TVALID/TLAST  out  1; M0_AXIS_TREADY  in  1; M0_AXIS_TDATA  out  DATA_WIDTH  results for requester 0.
REQ-011 M1_AXIS_* as REQ-010  results for requester 1.
REQ-012 GRANT  out  2  one-hot current input grant; 00 when idle.
REQ-013 INFLIGHT  out  clog2(TAG_DEPTH)+1  tag FIFO occupancy.

Function
REQ-014 Input FSM states IDLE, GNT0, GNT1; arbitration packet-granular, never switches mid-packet.
REQ-015 IDLE: all S*_TREADY=0, FIR_IN_TVALID=0; if tag FIFO not full and any S*_TVALID=1, next state GNTn for selected n.
REQ-016 Selection: single requester valid -> that one; both valid -> requester != last-granted (round-robin pointer).
REQ-017 Tag n pushed into tag FIFO on the IDLE->GNTn edge; no push when FIFO full (grant withheld).
REQ-018 GNTn: FIR_IN_TVALID/TLAST/TDATA = Sn_AXIS_TVALID/TLAST/TDATA, Sn_AXIS_TREADY = FIR_IN_TREADY, other requester TREADY=0; pure combinational pass-through, zero added latency.
REQ-019 GNTn: beat accepted with TLAST=1 -> IDLE, pointer := n; exactly one IDLE bubble cycle between consecutive packets.
REQ-020 GNTn with TVALID low holds grant indefinitely; no timeout.
REQ-021 Tag FIFO: TAG_DEPTH entries of 1 bit, circular read/write pointers wrap modulo TAG_DEPTH; simultaneous push and pop leaves INFLIGHT unchanged.
REQ-022 Output demux: tag FIFO empty -> FIR_OUT_TREADY=0, M0/M1 TVALID=0.
REQ-023 Non-empty, head tag h: Mh_AXIS_TVALID = FIR_OUT_TVALID, Mh TDATA/TLAST = FIR_OUT TDATA/TLAST, FIR_OUT_TREADY = Mh_AXIS_TREADY; other M TVALID=0.
REQ-024 Pop head on FIR_OUT beat accepted with TLAST=1; next beat routes per new head.
REQ-025 M*_AXIS_TDATA/TLAST of the unselected port driven 0.
REQ-026 Packet order through FIR is in-order; result packets reach originating requester in grant order.
REQ-027 FIR_OUT_TVALID with empty tag FIFO is ignored (not accepted, not forwarded).

Reset
REQ-028 ARESETN low: FSM IDLE, pointer = requester 1 (so requester 0 wins first tie), tag FIFO empty, GRANT=00, INFLIGHT=0, all TVALID/TREADY outputs 0.
REQ-029 Reset mid-packet abandons partial packet and all in-flight tags; no recovery; upstream and FIR reset together with this block.

Verification
REQ-030 Both requesters valid after reset, 3-beat packets each, all ready=1 -> S0 packet granted first, then S1; GRANT 01, 00, 10; M0 receives first FIR packet, M1 second.
REQ-031 S0 only, two 1-beat packets back-to-back -> FIR_IN beats separated by one idle cycle; INFLIGHT 1 then 2 with FIR_OUT_TREADY held off.
REQ-032 TAG_DEPTH=4, FIR output stalled, 5 one-beat packets alternating S0/S1 -> 4 granted, INFLIGHT=4, fifth TREADY held 0 until one result popped, then granted.
REQ-033 M1_AXIS_TREADY=0 while head tag=1 -> FIR_OUT_TREADY=0, M0_AXIS_TVALID=0; release -> beats flow, tag popped on TLAST.
REQ-034 Simultaneous grant push and result pop at INFLIGHT=2 -> INFLIGHT stays 2; write pointer wraps 3->0 with correct routing.
REQ-035 ARESETN asserted mid-packet in GNT1 -> all outputs 0 asynchronously, GRANT=00, INFLIGHT=0; after release S0 and S1 tie grants S0.
